parser: RTL and testbench

- Streaming packet parser. Accepts a 32-bit-beat packet stream, strips and decodes the 8-byte header, and packs the stream ID, sequence number and leading payload bytes into one 296-bit record.
- Tracks the sequence number of each stream and flags gaps with packetLost.
- Sits between a byte-stream ingress link and a downstream message consumer.

---
 rtl/parser.sv | 150 +++++++++++++++
 tb/tb_parser.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parser.sv
// Streaming header parser: decodes the 8-byte header and packs stream ID, seq and up to 30 payload bytes into one record.
// Latency: the record is valid on the cycle after the beat carrying dataIN_last is accepted.
// Backpressure: dataIn_ready drops only while a record is held and dataOut_ready is low. No beat is taken that could not be stored.
module parser #(
  parameter int SLOT_BITS = 4
) (
  input  logic           clk,
  input  logic           reset_b,
  input  logic [31:0]    dataIn,
  input  logic           dataIn_val,
  output logic           dataIn_ready,
  input  logic           dataIN_last,
  output logic [0:295]   dataOut,
  output logic           dataOut_val,
  input  logic           dataOut_ready,
  output logic           packetLost
);

  localparam int SLOTS = 1 << SLOT_BITS;

  typedef enum logic [1:0] {HDR0, HDR1, PAYLOAD} parseState;

  parseState         state, stateNext;
  logic [15:0]       lenReg, sidReg;
  logic [31:0]       seqReg;
  logic [0:29][7:0]  payBuf, payNext;
  logic [3:0]        beatIdx;      // payload beats captured; saturates at 8 (30 bytes)
  logic [4:0]        byteSel;
  logic [SLOTS-1:0]  slotValid;
  logic [31:0]       slotSeq [SLOTS];
  logic [SLOT_BITS-1:0] slot;
  logic [7:0]        byteCnt;
  logic              lostNext;
  logic [0:295]      recNext;
  logic              beatAcc, recLoad, recXfer;

  // State register
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) state <= HDR0;
    else         state <= stateNext;
  end

  // Next state: header beats advance, any accepted last beat restarts at HDR0
  always_comb begin
    stateNext = state;
    if (beatAcc) begin
      if (dataIN_last) begin
        stateNext = HDR0;
      end else begin
        case (state)
          HDR0:    stateNext = HDR1;
          HDR1:    stateNext = PAYLOAD;
          default: stateNext = PAYLOAD;
        endcase
      end
    end
  end

  // FSM outputs: handshake qualifiers; a record loads only when the packet got past its header
  always_comb begin
    dataIn_ready = !(dataOut_val && !dataOut_ready);
    beatAcc      = dataIn_val && dataIn_ready;
    recLoad      = beatAcc && dataIN_last && (state == PAYLOAD);
    recXfer      = dataOut_val && dataOut_ready;
  end

  // Header field capture (little-endian fields in the byte stream)
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      lenReg <= '0;
      sidReg <= '0;
      seqReg <= '0;
    end else if (beatAcc) begin
      if (state == HDR0) begin
        lenReg <= {dataIn[23:16], dataIn[31:24]};
        sidReg <= {dataIn[7:0], dataIn[15:8]};
      end else if (state == HDR1) begin
        seqReg <= {dataIn[7:0], dataIn[15:8], dataIn[23:16], dataIn[31:24]};
      end
    end
  end

  // Merge the current payload beat into the buffer view so the last beat lands in the record too
  always_comb begin
    payNext = payBuf;
    byteSel = '0;
    if (state == PAYLOAD && !beatIdx[3]) begin
      for (int i = 0; i < 4; i++) begin
        byteSel = {beatIdx[2:0], i[1:0]};
        if (byteSel < 5'd30) payNext[byteSel] = dataIn[8*(3-i) +: 8];
      end
    end
  end

  // Payload buffer: cleared on each header start, filled until 30 bytes are held
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      payBuf  <= '0;
      beatIdx <= '0;
    end else if (beatAcc) begin
      if (state == HDR0) begin
        payBuf  <= '0;
        beatIdx <= '0;
      end else if (state == PAYLOAD) begin
        payBuf <= payNext;
        if (!beatIdx[3]) beatIdx <= beatIdx + 4'd1;
      end
    end
  end

  // Record assembly: byte count from the length field, bytes past the count forced to zero
  always_comb begin
    if (lenReg <= 16'd8)       byteCnt = 8'd0;
    else if (lenReg >= 16'd38) byteCnt = 8'd30;
    else                       byteCnt = lenReg[7:0] - 8'd8;
    slot     = sidReg[SLOT_BITS-1:0];
    lostNext = slotValid[slot] && (seqReg != slotSeq[slot] + 32'd1);
    recNext  = {sidReg, seqReg, byteCnt, 240'b0};
    for (int k = 0; k < 30; k++) begin
      if (k < int'(byteCnt)) recNext[56+8*k +: 8] = payNext[k];
    end
  end

  // Output register: a load wins over a concurrent transfer so val stays high
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      dataOut     <= '0;
      dataOut_val <= 1'b0;
      packetLost  <= 1'b0;
    end else if (recLoad) begin
      dataOut     <= recNext;
      dataOut_val <= 1'b1;
      packetLost  <= lostNext;
    end else if (recXfer) begin
      dataOut_val <= 1'b0;
    end
  end

  // Sequence table: updated on the same edge the record is loaded
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      slotValid <= '0;
      for (int s = 0; s < SLOTS; s++) slotSeq[s] <= '0;
    end else if (recLoad) begin
      slotValid[slot] <= 1'b1;
      slotSeq[slot]   <= seqReg;
    end
  end

endmodule

// File: tb/tb_parser.sv
// Bench for parser: directed scenarios with literal expectations plus randomized packets
// checked every cycle against a byte-level packet model.
module tb_parser;

  logic           clk = 1'b0;
  logic           reset_b;
  logic [31:0]    dataIn;
  logic           dataIn_val;
  logic           dataIn_ready;
  logic           dataIN_last;
  logic [0:295]   dataOut;
  logic           dataOut_val;
  logic           dataOut_ready;
  logic           packetLost;

  int checks = 0;
  int errors = 0;
  int readyMode = 1;   // 0: hold low, 1: hold high, 2: random

  typedef struct {
    logic [0:295] rec;
    logic         lost;
  } expT;

  expT          expQ[$];
  logic [31:0]  curBeats[$];
  bit           slotV[16];
  logic [31:0]  slotS[16];
  logic [7:0]   pay[64];

  localparam logic [0:295] T1REC = {16'h000C, 32'h0, 8'd12, 96'h0C0014020C0014030C001404, 144'h0};

  parser #(.SLOT_BITS(4)) dut (
    .clk(clk), .reset_b(reset_b),
    .dataIn(dataIn), .dataIn_val(dataIn_val), .dataIn_ready(dataIn_ready), .dataIN_last(dataIN_last),
    .dataOut(dataOut), .dataOut_val(dataOut_val), .dataOut_ready(dataOut_ready), .packetLost(packetLost)
  );

  always #5 clk = ~clk;

  task automatic chkB(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s: got %b expected %b", name, act, exp); end
  endtask

  task automatic chk1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s: got %h expected %h", name, act, exp); end
  endtask

  task automatic chkR(input string name, input logic [0:295] act, input logic [0:295] exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s: got %h expected %h", name, act, exp); end
  endtask

  // Model: decode a whole packet from its bytes and predict the record
  task automatic finishPacket();
    logic [31:0] b0, b1, bw;
    logic [15:0] len, sid;
    logic [31:0] seq;
    int cnt, nbytes, sl;
    expT e;
    if (curBeats.size() < 3) return;
    b0 = curBeats[0];
    b1 = curBeats[1];
    len = {b0[23:16], b0[31:24]};
    sid = {b0[7:0], b0[15:8]};
    seq = {b1[7:0], b1[15:8], b1[23:16], b1[31:24]};
    cnt = int'(len) - 8;
    if (cnt < 0) cnt = 0;
    if (cnt > 30) cnt = 30;
    nbytes = (curBeats.size() - 2) * 4;
    e.rec = '0;
    e.rec[0:15]  = sid;
    e.rec[16:47] = seq;
    e.rec[48:55] = 8'(cnt);
    for (int k = 0; k < cnt && k < nbytes; k++) begin
      bw = curBeats[2 + k/4];
      e.rec[56+8*k +: 8] = bw[31-8*(k%4) -: 8];
    end
    sl = int'(sid) % 16;
    e.lost = slotV[sl] && (seq != slotS[sl] + 32'd1);
    slotV[sl] = 1'b1;
    slotS[sl] = seq;
    expQ.push_back(e);
  endtask

  // Compare process: outputs checked against the model every cycle, then the model advances
  always @(negedge clk) begin
    if (reset_b) begin
      chkB("rst_val", dataOut_val, 1'b0);
      chkB("rst_lost", packetLost, 1'b0);
      chkB("rst_ready", dataIn_ready, 1'b1);
      chkR("rst_dataOut", dataOut, '0);
      curBeats.delete();
      expQ.delete();
      for (int i = 0; i < 16; i++) slotV[i] = 1'b0;
    end else begin
      chkB("in_ready", dataIn_ready, !(dataOut_val && !dataOut_ready));
      chkB("out_val", dataOut_val, expQ.size() != 0);
      if (dataOut_val && expQ.size() != 0) begin
        chkR("out_rec", dataOut, expQ[0].rec);
        chkB("out_lost", packetLost, expQ[0].lost);
      end
      if (dataOut_val && dataOut_ready && expQ.size() != 0) void'(expQ.pop_front());
      if (dataIn_val && dataIn_ready) begin
        curBeats.push_back(dataIn);
        if (dataIN_last) begin
          finishPacket();
          curBeats.delete();
        end
      end
    end
  end

  // Consumer ready driver
  initial begin
    dataOut_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (readyMode)
        0:       dataOut_ready = 1'b0;
        1:       dataOut_ready = 1'b1;
        default: dataOut_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic sendBeat(input logic [31:0] w, input logic last);
    int n;
    dataIn = w; dataIn_val = 1'b1; dataIN_last = last;
    n = 0;
    @(negedge clk);
    while (!dataIn_ready && n < 200) begin n++; @(negedge clk); end
    if (!dataIn_ready) begin
      checks++; errors++;
      $display("FAIL beat_timeout: dataIn_ready stayed %b, required 1", dataIn_ready);
    end
    @(posedge clk); #1;
    dataIn_val = 1'b0; dataIN_last = 1'b0;
  endtask

  task automatic sendPkt(input logic [15:0] sid, input logic [31:0] seq, input logic [15:0] len,
                         input int nb, input bit gaps);
    logic [31:0] w;
    for (int i = 0; i < nb; i++) begin
      if (i == 0)      w = {len[7:0], len[15:8], sid[7:0], sid[15:8]};
      else if (i == 1) w = {seq[7:0], seq[15:8], seq[23:16], seq[31:24]};
      else             w = {pay[4*(i-2)], pay[4*(i-2)+1], pay[4*(i-2)+2], pay[4*(i-2)+3]};
      if (gaps && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      sendBeat(w, i == nb - 1);
    end
  endtask

  task automatic waitRec(output logic [0:295] d, output logic lost, output int n);
    n = 0; d = '0; lost = 1'b0;
    do begin @(negedge clk); n++; end while (!(dataOut_val && dataOut_ready) && n < 200);
    if (!(dataOut_val && dataOut_ready)) begin
      checks++; errors++;
      $display("FAIL rec_timeout: no record transfer, val=%b ready=%b", dataOut_val, dataOut_ready);
    end else begin
      d = dataOut; lost = packetLost;
    end
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    reset_b = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    reset_b = 1'b0;
  endtask

  task automatic randPay();
    for (int k = 0; k < 64; k++) pay[k] = 8'($urandom);
  endtask

  int t2sid[5]  = '{14, 12, 14, 12, 14};
  int t2seq[5]  = '{0, 0, 2, 1, 3};
  bit t2lost[5] = '{0, 0, 1, 0, 0};
  logic [31:0] rs[5];
  int          rsid[5] = '{3, 19, 35, 7, 1000};

  initial begin
    logic [0:295] d, d0;
    logic lost, lost0;
    int n, idx;
    logic [31:0] seq;

    dataIn = '0; dataIn_val = 1'b0; dataIN_last = 1'b0;
    doReset();

    // 1: reference packet from the test plan
    pay[0]=8'h0C; pay[1]=8'h00; pay[2]=8'h14; pay[3]=8'h02;
    pay[4]=8'h0C; pay[5]=8'h00; pay[6]=8'h14; pay[7]=8'h03;
    pay[8]=8'h0C; pay[9]=8'h00; pay[10]=8'h14; pay[11]=8'h04;
    sendPkt(16'd12, 32'd0, 16'd20, 5, 0);
    waitRec(d, lost, n);
    chk1("t1_latency", n, 1);
    chkR("t1_rec", d, T1REC);
    chkB("t1_lost", lost, 1'b0);

    // 2: interleaved streams, single gap on stream 14
    doReset();
    for (int i = 0; i < 5; i++) begin
      randPay();
      sendPkt(16'(t2sid[i]), 32'(t2seq[i]), 16'd12, 3, 0);
      waitRec(d, lost, n);
      chkB("t2_lost", lost, t2lost[i]);
      chk1("t2_sid", 32'(d[0:15]), 32'(t2sid[i]));
    end

    // 3: long packet, payload truncated to 30 bytes
    for (int k = 0; k < 64; k++) pay[k] = 8'(k + 1);
    sendPkt(16'd14, 32'd4, 16'd47, 10, 0);
    waitRec(d, lost, n);
    chk1("t3_count", 32'(d[48:55]), 32'd30);
    chk1("t3_byte0", 32'(d[56:63]), 32'h01);
    chk1("t3_byte29", 32'(d[288:295]), 32'h1E);
    chkB("t3_lost", lost, 1'b0);

    // 4: backpressure holds the record and stalls input
    readyMode = 0;
    repeat (2) begin @(posedge clk); #1; end
    randPay();
    sendPkt(16'd12, 32'd2, 16'd16, 4, 0);
    @(negedge clk);
    chkB("t4_val", dataOut_val, 1'b1);
    d0 = dataOut; lost0 = packetLost;
    chkB("t4_lost0", lost0, 1'b0);
    fork
      sendPkt(16'd12, 32'd3, 16'd16, 4, 0);
      begin
        repeat (8) begin
          @(negedge clk);
          chkB("t4_in_stall", dataIn_ready, 1'b0);
          chkR("t4_hold", dataOut, d0);
          chkB("t4_hold_lost", packetLost, lost0);
        end
        readyMode = 1;
      end
    join
    waitRec(d, lost, n);
    chk1("t4_seq2", d[16:47], 32'd3);
    chkB("t4_lost2", lost, 1'b0);

    // 5: truncated headers emit nothing and leave the slot untouched
    sendPkt(16'd5, 32'd7, 16'd12, 2, 0);
    sendPkt(16'd5, 32'd8, 16'd12, 1, 0);
    repeat (4) begin @(negedge clk); chkB("t5_noval", dataOut_val, 1'b0); end
    @(posedge clk); #1;
    randPay();
    sendPkt(16'd5, 32'd9, 16'd12, 3, 0);
    waitRec(d, lost, n);
    chkB("t5_lost", lost, 1'b0);

    // 6: reset mid-packet
    sendBeat({8'd16, 8'd0, 8'd14, 8'd0}, 1'b0);
    sendBeat(32'h32000000, 1'b0);
    sendBeat(32'hDEADBEEF, 1'b0);
    reset_b = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chkB("t6_rst_val", dataOut_val, 1'b0);
      chkR("t6_rst_data", dataOut, '0);
    end
    @(posedge clk); #1;
    reset_b = 1'b0;
    randPay();
    sendPkt(16'd14, 32'd100, 16'd16, 4, 0);
    waitRec(d, lost, n);
    chkB("t6_lost", lost, 1'b0);
    chk1("t6_seq", d[16:47], 32'd100);
    chk1("t6_count", 32'(d[48:55]), 32'd8);

    // Random traffic with aliasing stream IDs and random consumer stalls
    for (int i = 0; i < 5; i++) rs[i] = $urandom;
    rs[0] = 32'hFFFFFFFE;
    readyMode = 2;
    for (int p = 0; p < 200; p++) begin
      idx = $urandom_range(0, 4);
      seq = rs[idx];
      if ($urandom_range(0, 4) == 0) seq = seq + 32'($urandom_range(2, 5));
      rs[idx] = seq + 32'd1;
      randPay();
      sendPkt(16'(rsid[idx]), seq, 16'($urandom_range(0, 60)), $urandom_range(1, 14), 1);
    end
    readyMode = 1;
    repeat (10) @(negedge clk);
    chk1("drain", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
